des_feistel_round: RTL



---
 rtl/des_feistel_round_if.sv | 28 ++
 rtl/des_feistel_round.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/des_feistel_round_if.sv
// Block-stream interface for one DES Feistel round: input handshake with L/R halves,
// round key and tag, and the output handshake with the new halves and tag.
interface des_feistel_round_if #(
  parameter int TAG_W = 4
);
  // Halves and key are MSB-first: index 31 (or 47) holds DES bit 1
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      l_in;
  logic [31:0]      r_in;
  logic [47:0]      subkey;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      l_out;
  logic [31:0]      r_out;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, l_in, r_in, subkey, tag_in, out_ready,
    input  in_ready, out_valid, l_out, r_out, tag_out
  );

  modport slave (
    input  in_valid, l_in, r_in, subkey, tag_in, out_ready,
    output in_ready, out_valid, l_out, r_out, tag_out
  );
endinterface

// File: rtl/des_feistel_round.sv
// One DES round in three valid/ready stages: E(R)^K, S-box substitution, then P, XOR with L
// and the half swap (suppressed for the last round).
module des_feistel_round #(
  parameter int FINAL_ROUND = 0,
  parameter int TAG_W       = 4
) (
  input logic clk,
  input logic rst_n,
  des_feistel_round_if.slave bus
);

  localparam logic [5:0] E_TAB [48] = '{
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };

  localparam logic [5:0] P_TAB [32] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // Each S-box is 64 nibbles, row-major (row = b1b6, col = b2..b5), entry 0 in the top nibble
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  function automatic logic [47:0] des_expand(input logic [31:0] r);
    logic [47:0] e;
    e = 48'h0;
    for (int i = 0; i < 48; i++) begin
      e[47-i] = r[32-int'(E_TAB[i])];
    end
    return e;
  endfunction

  function automatic logic [31:0] des_sbox(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  g;
    logic [5:0]  idx;
    int          base;
    s = 32'h0;
    for (int b = 0; b < 8; b++) begin
      g    = x[47-6*b -: 6];
      idx  = {g[5], g[0], g[4:1]};
      base = 255 - 4*int'(idx);
      s[31-4*b -: 4] = SBOX_TAB[b][base -: 4];
    end
    return s;
  endfunction

  function automatic logic [31:0] des_permute(input logic [31:0] s);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < 32; i++) begin
      f[31-i] = s[32-int'(P_TAB[i])];
    end
    return f;
  endfunction

  logic             v1_r, v2_r, v3_r;
  logic [47:0]      x1_r;
  logic [31:0]      l1_r, r1_r, s2_r, l2_r, r2_r, l3_r, r3_r;
  logic [TAG_W-1:0] t1_r, t2_r, t3_r;
  logic             adv1_s, adv2_s, adv3_s, acc_s, ready_s;
  logic [31:0]      f_s;

  // Handshake: a stage moves when its successor is empty or moving this cycle
  always_comb begin
    adv3_s  = v3_r && bus.out_ready;
    adv2_s  = v2_r && (!v3_r || adv3_s);
    adv1_s  = v1_r && (!v2_r || adv2_s);
    ready_s = rst_n && (!v1_r || adv1_s);
    acc_s   = bus.in_valid && ready_s;
    f_s     = des_permute(s2_r);
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = v3_r;
  assign bus.l_out     = l3_r;
  assign bus.r_out     = r3_r;
  assign bus.tag_out   = t3_r;

  // Stage 1: capture the block and the key-mixed expansion of R
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      x1_r <= 48'h0;
      l1_r <= 32'h0;
      r1_r <= 32'h0;
      t1_r <= {TAG_W{1'b0}};
    end else if (acc_s) begin
      v1_r <= 1'b1;
      x1_r <= des_expand(bus.r_in) ^ bus.subkey;
      l1_r <= bus.l_in;
      r1_r <= bus.r_in;
      t1_r <= bus.tag_in;
    end else if (adv1_s) begin
      v1_r <= 1'b0;
    end else begin
      v1_r <= v1_r;
    end
  end

  // Stage 2: S-box substitution of the 48-bit word down to 32 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_r <= 1'b0;
      s2_r <= 32'h0;
      l2_r <= 32'h0;
      r2_r <= 32'h0;
      t2_r <= {TAG_W{1'b0}};
    end else if (adv1_s) begin
      v2_r <= 1'b1;
      s2_r <= des_sbox(x1_r);
      l2_r <= l1_r;
      r2_r <= r1_r;
      t2_r <= t1_r;
    end else if (adv2_s) begin
      v2_r <= 1'b0;
    end else begin
      v2_r <= v2_r;
    end
  end

  // Stage 3: apply f to L; the last round keeps halves in place instead of swapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_r <= 1'b0;
      l3_r <= 32'h0;
      r3_r <= 32'h0;
      t3_r <= {TAG_W{1'b0}};
    end else if (adv2_s) begin
      v3_r <= 1'b1;
      t3_r <= t2_r;
      if (FINAL_ROUND != 0) begin
        l3_r <= l2_r ^ f_s;
        r3_r <= r2_r;
      end else begin
        l3_r <= r2_r;
        r3_r <= l2_r ^ f_s;
      end
    end else if (adv3_s) begin
      v3_r <= 1'b0;
    end else begin
      v3_r <= v3_r;
    end
  end

endmodule
